// File: rtl/rv_mem_responder.sv
// ---------------------------------------------------------------------------
// rv_mem_responder
//   Word-addressed memory slave for the minrv32 valid/ready memory bus.
//   Provides real storage with byte-strobe writes, address-range and
//   alignment faulting, and bounded wait-state insertion so that every
//   request is answered within a known number of cycles.
//
//   Optional feature macro: RV_MEM_RANDWAIT_EN
//     defined   : wait states per access come from a 16-bit Fibonacci LFSR
//                 (taps 16,14,13,11), clamped to MAX_WAIT
//     undefined : every access waits exactly LATENCY cycles (no LFSR)
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high
//   mem_valid    in   request valid, fields held until mem_ready
//   mem_instr    in   instruction fetch marker (counted only)
//   mem_addr     in   [31:0] byte address
//   mem_wdata    in   [31:0] write data
//   mem_wstrb    in   [3:0]  byte write enables, 0 = read
//   mem_ready    out  one-cycle response strobe
//   mem_rdata    out  [31:0] read data, valid with mem_ready, held otherwise
//   fault        out  illegal-access flag, pulses with mem_ready
//   busy         out  high while in WAIT or RESP
//   stall_count  out  [15:0] saturating count of WAIT cycles
//   fetch_count  out  [15:0] saturating count of accepted fetches
// ---------------------------------------------------------------------------
module rv_mem_responder #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          LATENCY   = 1,
  parameter int          MAX_WAIT  = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        fault,
  output logic        busy,
  output logic [15:0] stall_count,
  output logic [15:0] fetch_count
);

  localparam int         DEPTH  = 2 ** ADDR_W;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] LAT_N  = 4'(LATENCY);
  localparam logic [3:0] MAXW_N = 4'(MAX_WAIT);

  // Elaboration-time parameter sanity checks.
  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("rv_mem_responder: LATENCY must be 0..15");
  end
  if (MAX_WAIT < 0 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("rv_mem_responder: MAX_WAIT must be 0..15");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("rv_mem_responder: LFSR_SEED must be nonzero");
  end
  if (BASE_ADDR[ADDR_W+1:0] != '0) begin : g_bad_base
    $error("rv_mem_responder: BASE_ADDR must be aligned to the memory size");
  end

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              illegal_q, illegal_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [15:0]       stall_q, stall_d;
  logic [15:0]       fetch_q, fetch_d;
  logic [31:0]       mem_q [DEPTH];

  logic              acc_illegal;
  logic [ADDR_W-1:0] acc_idx;
  logic [3:0]        n_acc;
  logic              load_rdata;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_illegal;

  // Base is size-aligned, so range membership is an upper-bit compare and
  // the word index is simply the low address bits.
  assign acc_illegal = (mem_addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]) ||
                       (mem_addr[1:0] != 2'b00);
  assign acc_idx     = mem_addr[ADDR_W+1:2];

`ifdef RV_MEM_RANDWAIT_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign n_acc   = (lfsr_q[3:0] > MAXW_N) ? MAXW_N : lfsr_q[3:0];

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end
`else
  assign n_acc = LAT_N;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    illegal_d  = illegal_q;
    stall_d    = stall_q;
    fetch_d    = fetch_q;
    load_rdata = 1'b0;
    rd_idx     = idx_q;
    rd_illegal = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          idx_d     = acc_idx;
          wdata_d   = mem_wdata;
          wstrb_d   = mem_wstrb;
          illegal_d = acc_illegal;
          if (mem_instr) fetch_d = sat_inc16(fetch_q);
          if (n_acc == 4'd0) begin
            // Zero-wait access: read straight from the live request fields.
            state_d    = S_RESP;
            load_rdata = 1'b1;
            rd_idx     = acc_idx;
            rd_illegal = acc_illegal;
          end else begin
            state_d = S_WAIT;
            cnt_d   = n_acc;
          end
        end
      end
      S_WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        stall_d = sat_inc16(stall_q);
        if (cnt_q == 4'd1) begin
          state_d    = S_RESP;
          load_rdata = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Read data is captured on the edge entering RESP, so a write response
    // returns the word as it was before this access's own write.
    if (load_rdata) rdata_d = rd_illegal ? 32'h0 : mem_q[rd_idx];
    else            rdata_d = rdata_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      stall_q <= 16'h0;
      fetch_q <= 16'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      stall_q <= stall_d;
      fetch_q <= fetch_d;
    end
  end

  always_ff @(posedge clock) begin
    idx_q     <= idx_d;
    wdata_q   <= wdata_d;
    wstrb_q   <= wstrb_d;
    illegal_q <= illegal_d;
  end

  // Writes commit on the RESP edge; a reset during RESP drops the write.
  always_ff @(posedge clock) begin
    if (!reset && state_q == S_RESP && !illegal_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign mem_ready   = (state_q == S_RESP);
  assign fault       = mem_ready & illegal_q;
  assign busy        = (state_q != S_IDLE);
  assign mem_rdata   = rdata_q;
  assign stall_count = stall_q;
  assign fetch_count = fetch_q;

endmodule

// File: tb/tb_rv_mem_responder.sv
module tb_rv_mem_responder;

  localparam int          LAT   = 2;
  localparam int          MAXW  = 3;
  localparam int          AW    = 10;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  logic        clock;
  logic        reset;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        fault;
  logic        busy;
  logic [15:0] stall_count;
  logic [15:0] fetch_count;

  rv_mem_responder #(
    .ADDR_W   (AW),
    .BASE_ADDR(BASE),
    .LATENCY  (LAT),
    .MAX_WAIT (MAXW),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .fault      (fault),
    .busy       (busy),
    .stall_count(stall_count),
    .fetch_count(fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: word store plus "known" flags, and expected counters.
  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];
  int          ref_stall = 0;
  int          ref_fetch = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a);
    logic [1:0] lo;
    lo = a[1:0];
    return (a >= BASE) && (a < BASE + 32'(4 * DEPTH)) && (lo == 2'b00);
  endfunction

  task automatic do_access(input string tag, input logic instr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input bit scramble);
    logic [31:0] exp_rd;
    bit          exp_flt, rd_known, got;
    int          k, idx;
    exp_flt  = !is_legal(addr);
    exp_rd   = 32'h0;
    rd_known = 1'b1;
    idx      = 0;
    if (!exp_flt) begin
      idx      = int'((addr - BASE) >> 2);
      exp_rd   = ref_mem[idx];
      rd_known = ref_known[idx];
    end
    if (mem_ready) begin
      @(posedge clock); #1;
    end
    mem_valid = 1'b1;
    mem_instr = instr;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    got = 1'b0;
    k   = 0;
    while (!got && k < 40) begin
      @(posedge clock); #1;
      k++;
      if (k == 1 && scramble) begin
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom_range(0, 15));
        mem_instr = 1'($urandom_range(0, 1));
      end
      if (mem_ready) got = 1'b1;
    end
    mem_valid = 1'b0;
    check({tag, " ready"}, 32'(got), 32'd1);
    if (got) begin
`ifdef RV_MEM_RANDWAIT_EN
      check({tag, " latency_in_range"}, 32'(k >= 1 && k <= MAXW + 1), 32'd1);
`else
      check({tag, " latency"}, 32'(k), 32'(LAT + 1));
`endif
      check({tag, " fault"}, 32'(fault), 32'(exp_flt));
      if (rd_known) check({tag, " rdata"}, mem_rdata, exp_rd);
    end
    if (!exp_flt) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
      if (wstrb == 4'hF) ref_known[idx] = 1'b1;
    end
    ref_stall += k - 1;
    ref_fetch += int'(instr);
  endtask

  initial begin
    int pulses;
    int r;
    logic [31:0] a;
    logic [3:0]  s;

    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]   = 32'h0;
      ref_known[i] = 1'b0;
    end
    reset     = 1'b1;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    repeat (3) @(posedge clock);
    #1;
    check("rst mem_ready", 32'(mem_ready), 32'd0);
    check("rst fault", 32'(fault), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst rdata", mem_rdata, 32'h0);
    check("rst stall", 32'(stall_count), 32'd0);
    check("rst fetch", 32'(fetch_count), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Full-word write then read-back, and rdata hold afterwards.
    do_access("t1 wr", 1'b0, 32'h0001_0000, 32'hDEAD_BEEF, 4'hF, 1'b0);
    do_access("t1 rd", 1'b1, 32'h0001_0000, 32'h0, 4'h0, 1'b0);
    @(posedge clock); #1;
    check("t1 rdata hold", mem_rdata, 32'hDEAD_BEEF);
    check("t1 idle busy", 32'(busy), 32'd0);

    // Byte-strobe merge, read-before-write on the partial write response.
    do_access("t2 wr full", 1'b0, 32'h0001_0004, 32'h1122_3344, 4'hF, 1'b0);
    do_access("t2 wr byte1", 1'b0, 32'h0001_0004, 32'h0000_AB00, 4'b0010, 1'b0);
    do_access("t2 rd", 1'b0, 32'h0001_0004, 32'h0, 4'h0, 1'b0);
    check("t2 merged", mem_rdata, 32'h1122_AB44);

    // Out-of-range accesses fault and never alias into the array.
    do_access("t3 rd zero", 1'b0, 32'h0000_0000, 32'h0, 4'h0, 1'b0);
    do_access("t3 wr zero", 1'b0, 32'h0000_0000, 32'h5555_5555, 4'hF, 1'b0);
    do_access("t3 rd base", 1'b0, 32'h0001_0000, 32'h0, 4'h0, 1'b0);

    // Misaligned write faults without touching memory.
    do_access("t4 wr misaligned", 1'b0, 32'h0001_0002, 32'hCAFE_F00D, 4'hF, 1'b0);
    do_access("t4 rd base", 1'b0, 32'h0001_0000, 32'h0, 4'h0, 1'b0);

    // Range boundaries; request fields scrambled after accept must be ignored.
    do_access("bnd wr last", 1'b1, 32'h0001_0FFC, 32'hA5A5_0001, 4'hF, 1'b1);
    do_access("bnd rd last", 1'b1, 32'h0001_0FFC, 32'h0, 4'h0, 1'b1);
    do_access("bnd rd end", 1'b0, 32'h0001_1000, 32'h0, 4'h0, 1'b0);
    do_access("bnd rd below", 1'b0, 32'h0000_FFFC, 32'h0, 4'h0, 1'b0);
    check("dir stall", 32'(stall_count), 32'(ref_stall));
    check("dir fetch", 32'(fetch_count), 32'(ref_fetch));

    // Reset in cycle t+2 after accept abandons a pending write.
    do_access("t5 wr init", 1'b0, 32'h0001_0008, 32'h0102_0304, 4'hF, 1'b0);
    @(posedge clock); #1;
    mem_valid = 1'b1;
    mem_instr = 1'b1;
    mem_addr  = 32'h0001_0008;
    mem_wdata = 32'h55AA_55AA;
    mem_wstrb = 4'hF;
    @(posedge clock); #1;
    check("t5 busy after accept", 32'(busy), 32'd1);
    @(posedge clock); #1;
    check("t5 no ready t+2", 32'(mem_ready), 32'd0);
    reset     = 1'b1;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check("t5 idle after reset", 32'(busy), 32'd0);
    check("t5 stall cleared", 32'(stall_count), 32'd0);
    check("t5 fetch cleared", 32'(fetch_count), 32'd0);
    ref_stall = 0;
    ref_fetch = 0;
    pulses = 0;
    repeat (6) begin
      if (mem_ready) pulses++;
      @(posedge clock); #1;
    end
    check("t5 ready pulses", 32'(pulses), 32'd0);
    do_access("t5 rd dropped", 1'b0, 32'h0001_0008, 32'h0, 4'h0, 1'b0);

    // Randomized back-to-back traffic over a pre-initialized window.
    for (int i = 0; i < 16; i++) begin
      do_access("rnd init", 1'b0, 32'h0001_0100 + 32'(4 * i), $urandom, 4'hF, 1'b0);
    end
    for (int i = 0; i < 1000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      a = 32'h0001_0100 + 32'(4 * $urandom_range(0, 15));
      else if (r < 90) a = 32'h0001_0100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      else             a = $urandom;
      s = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      do_access("rnd", 1'($urandom_range(0, 1)), a, $urandom, s, ($urandom_range(0, 3) == 0));
    end
    check("rnd stall", 32'(stall_count), 32'(ref_stall));
    check("rnd fetch", 32'(fetch_count), 32'(ref_fetch));

    @(posedge clock); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
